leb128_fetch: RTL

- Immediate-operand fetcher sitting between the `core` decode stage and `genrom`.
- On request, it reads a WebAssembly LEB128 immediate (i32/i64, signed or unsigned) byte by byte from ROM.
- It returns the decoded 64-bit value and the address of the first byte after the immediate.
- The core's `local.set`/`local.get` index and `i64.const` paths use it instead of decoding immediates inline.

---
 rtl/leb128_fetch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/leb128_fetch.sv
// LEB128 immediate fetcher: reads a (S|U)LEB128 i32/i64 immediate byte by byte from genrom.
// Optional macro LEB128_STRICT_EN checks the final byte's unused high bits (error 3).
module leb128_fetch #(
    parameter int MEM_DEPTH = 6,
    parameter int MEM_EXTRA = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [MEM_DEPTH:0]           start_addr,
    input  logic                         is_signed,
    input  logic                         is_64,
    output logic                         busy,
    output logic                         done,
    output logic [63:0]                  value,
    output logic [MEM_DEPTH:0]           next_addr,
    output logic [1:0]                   error,
    output logic [MEM_DEPTH:0]           mem_addr,
    output logic [MEM_EXTRA-1:0]         mem_extra,
    input  logic [2**MEM_EXTRA*8-1:0]    mem_data,
    input  logic                         mem_error
);

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, DONE} state_t;

    state_t             state, state_d;
    logic [MEM_DEPTH:0] cur_addr;
    logic [63:0]        acc;
    logic [6:0]         shift;
    logic [3:0]         count;
    logic               sgn, w64;

    logic [7:0]         byte_b;
    logic [6:0]         shift_new;
    logic [3:0]         count_new;
    logic [3:0]         max_cnt;
    logic [63:0]        acc_or;
    logic [63:0]        acc_fin;
    logic               strict_bad;
    logic               unused_ok;

    assign busy      = (state != IDLE);
    assign mem_extra = '0;
    assign unused_ok = ^mem_data[2**MEM_EXTRA*8-1:8];

    always_comb begin
        state_d    = state;
        byte_b     = mem_data[7:0];
        shift_new  = shift + 7'd7;
        count_new  = count + 4'd1;
        max_cnt    = w64 ? 4'd10 : 4'd5;
        // shift never exceeds 63 while a byte is being decoded
        acc_or     = acc | ({57'b0, byte_b[6:0]} << shift[5:0]);
        acc_fin    = acc_or;
        if (sgn && byte_b[6] && (shift_new < 7'd64))
            acc_fin = acc_fin | ({64{1'b1}} << shift_new[5:0]);
        if (!w64)
            acc_fin[63:32] = sgn ? {32{acc_fin[31]}} : '0;
        strict_bad = 1'b0;
`ifdef LEB128_STRICT_EN
        if (count_new == max_cnt) begin
            if (w64)
                strict_bad = sgn ? (byte_b[6:1] != {6{byte_b[0]}}) : (byte_b[6:1] != 6'd0);
            else
                strict_bad = sgn ? (byte_b[6:4] != {3{byte_b[3]}}) : (byte_b[6:4] != 3'd0);
        end
`endif
        case (state)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = DECODE;
            DECODE: begin
                if (!mem_error && byte_b[7] && (count_new != max_cnt))
                    state_d = FETCH;
                else
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            acc       <= '0;
            shift     <= '0;
            count     <= '0;
            sgn       <= 1'b0;
            w64       <= 1'b0;
            mem_addr  <= '0;
            done      <= 1'b0;
            value     <= '0;
            next_addr <= '0;
            error     <= '0;
        end else begin
            state <= state_d;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr <= start_addr;
                        sgn      <= is_signed;
                        w64      <= is_64;
                        acc      <= '0;
                        shift    <= '0;
                        count    <= '0;
                    end
                end
                FETCH: mem_addr <= cur_addr;
                DECODE: begin
                    if (mem_error) begin
                        done      <= 1'b1;
                        error     <= 2'd1;
                        value     <= acc;
                        next_addr <= cur_addr;
                    end else begin
                        acc      <= acc_or;
                        shift    <= shift_new;
                        count    <= count_new;
                        cur_addr <= cur_addr + 1'b1;
                        if (byte_b[7]) begin
                            if (count_new == max_cnt) begin
                                done      <= 1'b1;
                                error     <= 2'd2;
                                value     <= acc_or;
                                next_addr <= cur_addr + 1'b1;
                            end
                        end else begin
                            done      <= 1'b1;
                            error     <= strict_bad ? 2'd3 : 2'd0;
                            value     <= acc_fin;
                            next_addr <= cur_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
